serial_subtractor: RTL and testbench

- Bit/digit-serial subtractor: computes diff = a - b mod 2^WIDTH, LSB first, DIGIT bits per clock, with a registered borrow flip-flop.
- The inverse companion to the team's adder datapath. Used where the hashing core must undo or compare modular additions (e.g. recovering a word from a sum, comparing nonces) without a full-width carry chain.
- Valid/ready handshake on both input and output. One operation in flight at a time.

---
 rtl/serial_subtractor.sv | 131 +++++++++++++
 tb/tb_serial_subtractor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Digit-serial modular subtractor: diff = (a - b) mod 2^WIDTH, LSB first,
// DIGIT bits per clock through a registered borrow; valid/ready on both sides.
//
// Ports:
//   clk, rst             rising-edge clock, async active-high reset
//   in_valid, in_ready   operand handshake (a minuend, b subtrahend)
//   out_valid, out_ready result handshake (diff, borrow = unsigned a < b)
//   busy                 high while an operation is running or held
module serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy
);

  localparam int K  = WIDTH / DIGIT;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bf_q, bf_d;
  logic             borrow_q, borrow_d;
  logic             ov_q, ov_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT:0]   t;
  logic [WIDTH-1:0] r_nxt;

  // One digit of subtraction, one bit wider so the top bit is the borrow out.
  always_comb begin
    t = {1'b0, a_sh_q[DIGIT-1:0]}
      - {1'b0, b_sh_q[DIGIT-1:0]}
      - {{DIGIT{1'b0}}, bf_q};
    // New digit enters at the MSB end; after K shifts it lands in place.
    r_nxt = (r_sh_q >> DIGIT)
          | (WIDTH'(t[DIGIT-1:0]) << (WIDTH - DIGIT));
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    r_sh_d   = r_sh_q;
    diff_d   = diff_q;
    bf_d     = bf_q;
    borrow_d = borrow_q;
    ov_d     = ov_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          bf_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> DIGIT;
        b_sh_d = b_sh_q >> DIGIT;
        r_sh_d = r_nxt;
        bf_d   = t[DIGIT];
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(K - 1)) begin
          diff_d   = r_nxt;
          borrow_d = t[DIGIT];
          ov_d     = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      r_sh_q   <= '0;
      diff_q   <= '0;
      bf_q     <= 1'b0;
      borrow_q <= 1'b0;
      ov_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      r_sh_q   <= r_sh_d;
      diff_q   <= diff_d;
      bf_q     <= bf_d;
      borrow_q <= borrow_d;
      ov_q     <= ov_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = ov_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor, DIGIT=1 and DIGIT=4
// instances side by side, one active at a time.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv = 1'b0;
  logic        sel = 1'b0;
  logic        ordy = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic        ir1, ov1, bw1, bs1;
  logic [31:0] d1;
  logic        ir4, ov4, bw4, bs4;
  logic [31:0] d4;

  logic        ir_m, ov_m, bw_m, bs_m;
  logic [31:0] d_m;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(32), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst),
    .in_valid(iv & ~sel), .in_ready(ir1),
    .a(a), .b(b),
    .out_valid(ov1), .out_ready(ordy),
    .diff(d1), .borrow(bw1), .busy(bs1)
  );

  serial_subtractor #(.WIDTH(32), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst),
    .in_valid(iv & sel), .in_ready(ir4),
    .a(a), .b(b),
    .out_valid(ov4), .out_ready(ordy),
    .diff(d4), .borrow(bw4), .busy(bs4)
  );

  assign ir_m = sel ? ir4 : ir1;
  assign ov_m = sel ? ov4 : ov1;
  assign bw_m = sel ? bw4 : bw1;
  assign bs_m = sel ? bs4 : bs1;
  assign d_m  = sel ? d4  : d1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full operation with out_ready high; checks latency, result, return to IDLE.
  task automatic do_op(input logic [31:0] oa,
                       input logic [31:0] ob,
                       input logic [31:0] ed,
                       input logic        eb);
    int lat;
    int lexp;
    lexp = sel ? 8 : 32;
    ordy = 1'b1;
    a = oa;
    b = ob;
    iv = 1'b1;
    chk("in_ready_idle", 32'(ir_m), 32'd1);
    step();
    iv = 1'b0;
    a = '0;
    b = '0;
    lat = 0;
    while (!ov_m && lat < 100) begin
      chk("in_ready_run", 32'(ir_m), 32'd0);
      step();
      lat++;
    end
    chk("latency", 32'(lat), 32'(lexp));
    chk("diff", d_m, ed);
    chk("borrow", 32'(bw_m), 32'(eb));
    step();
    chk("ov_after_hs", 32'(ov_m), 32'd0);
    chk("in_ready_after_hs", 32'(ir_m), 32'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    #12;
    chk("rst_ov", 32'(ov1), 32'd0);
    chk("rst_diff", d1, 32'd0);
    chk("rst_borrow", 32'(bw1), 32'd0);
    chk("rst_busy", 32'(bs1), 32'd0);
    chk("rst_in_ready", 32'(ir1), 32'd1);
    rst = 1'b0;
    step();

    do_op(32'd5, 32'd3, 32'h0000_0002, 1'b0);
    do_op(32'd0, 32'd1, 32'hFFFF_FFFF, 1'b1);
    do_op(32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    do_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 1'b0);
    do_op(32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b1);

    // Backpressure, with in_valid noise during RUN and DONE.
    ordy = 1'b0;
    a = 32'd100;
    b = 32'd1;
    iv = 1'b1;
    step();
    for (int i = 0; i < 40 && !ov1; i++) begin
      iv = i[0];
      a = 32'h1234_0000 + 32'(i);
      b = 32'h0000_FFFF;
      step();
    end
    chk("bp_ov_rise", 32'(ov1), 32'd1);
    for (int i = 0; i < 10; i++) begin
      iv = ~i[0];
      a = 32'hCAFE_0000;
      b = 32'h1;
      chk("bp_ov", 32'(ov1), 32'd1);
      chk("bp_diff", d1, 32'd99);
      chk("bp_borrow", 32'(bw1), 32'd0);
      chk("bp_in_ready", 32'(ir1), 32'd0);
      chk("bp_busy", 32'(bs1), 32'd1);
      step();
    end
    iv = 1'b0;
    ordy = 1'b1;
    step();
    chk("bp_ov_drop", 32'(ov1), 32'd0);
    chk("bp_idle", 32'(ir1), 32'd1);
    chk("bp_diff_kept", d1, 32'd99);
    step();
    chk("bp_single_hs", 32'(ov1), 32'd0);
    chk("bp_still_idle", 32'(bs1), 32'd0);

    // Reset in the middle of RUN.
    a = 32'd7;
    b = 32'd2;
    iv = 1'b1;
    step();
    iv = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("mid_busy", 32'(bs1), 32'd1);
    rst = 1'b1;
    #1;
    chk("mrst_ov", 32'(ov1), 32'd0);
    chk("mrst_diff", d1, 32'd0);
    chk("mrst_borrow", 32'(bw1), 32'd0);
    chk("mrst_busy", 32'(bs1), 32'd0);
    chk("mrst_in_ready", 32'(ir1), 32'd1);
    #2;
    rst = 1'b0;
    step();
    for (int i = 0; i < 40; i++) begin
      if (ov1) chk("mrst_no_output", 32'(ov1), 32'd0);
      step();
    end
    do_op(32'd9, 32'd4, 32'd5, 1'b0);

    // DIGIT=4 instance.
    sel = 1'b1;
    do_op(32'd0, 32'd1, 32'hFFFF_FFFF, 1'b1);
    do_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 7 == 0) rb = ra;
      do_op(ra, rb, ra - rb, ra < rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
